dram_wr_buf: RTL and testbench

Store-path counterpart of the load-data writeback extraction in hxd32. It accepts store requests from the MEM stage (SB/SH/SW) and places the store data into the correct byte lanes with matching byte enables. Requests are queued in a small FIFO and drained to the data RAM over a valid/ready handshake. It signals full so the pipeline stalls, and busy so loads can be held until earlier stores have drained.

---
 rtl/dram_wr_buf_pkg.sv | 23 ++
 rtl/dram_wr_buf_wr_lane_align.sv | 41 ++++
 rtl/dram_wr_buf.sv | 123 ++++++++++++
 tb/tb_dram_wr_buf.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_wr_buf_pkg.sv
// Shared DRAM access codes and the store-buffer entry layout.
// Used by dram_wr_buf and its lane-alignment helper.
package dram_wr_buf_pkg;

  localparam int WR_XLEN = 32;

  localparam logic [2:0] DRAM_RD_B  = 3'd1;
  localparam logic [2:0] DRAM_RD_BU = 3'd2;
  localparam logic [2:0] DRAM_RD_H  = 3'd3;
  localparam logic [2:0] DRAM_RD_HU = 3'd4;
  localparam logic [2:0] DRAM_RD_W  = 3'd5;

  localparam logic [2:0] DRAM_WR_B  = 3'd1;
  localparam logic [2:0] DRAM_WR_H  = 3'd2;
  localparam logic [2:0] DRAM_WR_W  = 3'd3;

  typedef struct packed {
    logic [WR_XLEN-1:0] addr;
    logic [WR_XLEN-1:0] data;
    logic [3:0]         be;
  } wr_entry_t;

endpackage

// File: rtl/dram_wr_buf_wr_lane_align.sv
// Combinational store lane alignment: replicates store data across byte lanes
// and produces byte enables plus a misalignment flag for valid width codes.
module wr_lane_align
  import dram_wr_buf_pkg::*;
(
  input  logic [2:0]  sel_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o,
  output logic        sel_ok_o,
  output logic        misalign_o
);

  always_comb begin
    data_o     = data_i;
    be_o       = 4'b0000;
    sel_ok_o   = 1'b0;
    misalign_o = 1'b0;
    case (sel_i)
      DRAM_WR_B: begin
        sel_ok_o = 1'b1;
        data_o   = {4{data_i[7:0]}};
        be_o     = 4'b0001 << addr_i;
      end
      DRAM_WR_H: begin
        sel_ok_o   = 1'b1;
        data_o     = {2{data_i[15:0]}};
        be_o       = 4'b0011 << addr_i;
        misalign_o = addr_i[0];
      end
      DRAM_WR_W: begin
        sel_ok_o   = 1'b1;
        be_o       = 4'b1111;
        misalign_o = (addr_i != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dram_wr_buf.sv
// Store write buffer: aligns SB/SH/SW requests into byte lanes, queues them in
// a small FIFO and drains them to data RAM. Optional DRAM_WR_BUF_BYPASS_EN.
module dram_wr_buf
  import dram_wr_buf_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            dram_wr_en_i,
  input  logic [2:0]      dram_wr_sel_i,
  input  logic [XLEN-1:0] dram_wr_addr_i,
  input  logic [XLEN-1:0] dram_wr_data_i,
  output logic            dram_wr_full_o,
  output logic            dram_wr_busy_o,
  output logic            dram_wr_misalign_o,
  output logic            mem_wr_valid_o,
  input  logic            mem_wr_ready_i,
  output logic [XLEN-1:0] mem_wr_addr_o,
  output logic [XLEN-1:0] mem_wr_data_o,
  output logic [3:0]      mem_wr_byte_en_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

  // Handshake: an entry transfers on any edge where mem_wr_valid_o && mem_wr_ready_i.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          misalign_q, misalign_d;
  wr_entry_t     mem_q [DEPTH];
  wr_entry_t     mem_d [DEPTH];
  wr_entry_t     last_q, last_d;

  logic [31:0] al_data;
  logic [3:0]  al_be;
  logic        al_ok, al_mis;
  wr_entry_t   new_ent, out_ent;
  logic        full, empty, accept, byp, valid, fifo_deq, enq;

  wr_lane_align u_align (
    .sel_i      (dram_wr_sel_i),
    .addr_i     (dram_wr_addr_i[1:0]),
    .data_i     (dram_wr_data_i),
    .data_o     (al_data),
    .be_o       (al_be),
    .sel_ok_o   (al_ok),
    .misalign_o (al_mis)
  );

  assign new_ent = '{addr: {dram_wr_addr_i[XLEN-1:2], 2'b00}, data: al_data, be: al_be};
  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  // Full comes from the registered count only, so ready never reaches it.
  assign accept  = dram_wr_en_i & al_ok & ~al_mis & ~full;

`ifdef DRAM_WR_BUF_BYPASS_EN
  assign byp = accept & empty;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    out_ent  = last_q;
    valid    = 1'b0;
    if (!empty) begin
      out_ent = mem_q[rd_ptr_q];
      valid   = 1'b1;
    end else if (byp) begin
      out_ent = new_ent;
      valid   = 1'b1;
    end
    fifo_deq = ~empty & mem_wr_ready_i;
    enq      = accept & ~(byp & mem_wr_ready_i);

    mem_d = mem_q;
    if (enq) mem_d[wr_ptr_q] = new_ent;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq)      wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (fifo_deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (enq && !fifo_deq)      cnt_d = cnt_q + CNT_ONE;
    else if (!enq && fifo_deq) cnt_d = cnt_q - CNT_ONE;

    // Remember what was last presented so the bus holds it once empty.
    last_d     = valid ? out_ent : last_q;
    misalign_d = dram_wr_en_i & al_mis;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      last_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      last_q     <= last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign dram_wr_full_o     = full;
  assign dram_wr_busy_o     = ~empty;
  assign dram_wr_misalign_o = misalign_q;
  assign mem_wr_valid_o     = valid;
  assign mem_wr_addr_o      = out_ent.addr;
  assign mem_wr_data_o      = out_ent.data;
  assign mem_wr_byte_en_o   = out_ent.be;

endmodule

// File: tb/tb_dram_wr_buf.sv
// Directed bench for dram_wr_buf: lane alignment, ordering, full/busy,
// misalignment pulses, pointer wrap and asynchronous reset.
module tb_dram_wr_buf;
  import dram_wr_buf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  sel;
  logic [31:0] addr, data;
  logic        full, busy, misalign, valid, ready;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_be;

  int n_tests = 0;
  int n_fail  = 0;
  logic [67:0] exp_q[$];

  dram_wr_buf #(.XLEN(32), .DEPTH(4)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .dram_wr_en_i       (en),
    .dram_wr_sel_i      (sel),
    .dram_wr_addr_i     (addr),
    .dram_wr_data_i     (data),
    .dram_wr_full_o     (full),
    .dram_wr_busy_o     (busy),
    .dram_wr_misalign_o (misalign),
    .mem_wr_valid_o     (valid),
    .mem_wr_ready_i     (ready),
    .mem_wr_addr_o      (m_addr),
    .mem_wr_data_o      (m_data),
    .mem_wr_byte_en_o   (m_be)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    en   = 1'b1;
    sel  = s;
    addr = a;
    data = d;
  endtask

  task automatic idle();
    en = 1'b0;
  endtask

  task automatic expect_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_q.push_back({a, d, be});
  endtask

  // Scoreboard: every handshake must match the oldest expected transfer.
  always @(negedge clk) begin
    logic [67:0] e;
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("xfer_unexpected", {32'h0, m_addr}, 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("xfer_addr", {32'h0, m_addr}, {32'h0, e[67:36]});
        check("xfer_data", {32'h0, m_data}, {32'h0, e[35:4]});
        check("xfer_be",   {60'h0, m_be},   {60'h0, e[3:0]});
      end
    end
  end

  initial begin
    en = 1'b0; sel = 3'd0; addr = '0; data = '0; ready = 1'b0; rst_n = 1'b0;
    #12;
    check("rst_valid", {63'h0, valid}, 64'h0);
    check("rst_full", {63'h0, full}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_misalign", {63'h0, misalign}, 64'h0);
    check("rst_addr", {32'h0, m_addr}, 64'h0);
    check("rst_data", {32'h0, m_data}, 64'h0);
    check("rst_be", {60'h0, m_be}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // SB to the top byte lane
    ready = 1'b1;
    drive(DRAM_WR_B, 32'h103, 32'h0000_00A5);
    expect_xfer(32'h100, 32'hA5A5_A5A5, 4'b1000);
    tick();
    idle();
    check("sb_valid", {63'h0, valid}, 64'h1);
    check("sb_addr", {32'h0, m_addr}, 64'h100);
    check("sb_data", {32'h0, m_data}, 64'hA5A5_A5A5);
    check("sb_be", {60'h0, m_be}, 64'h8);
    tick();
    check("sb_done_valid", {63'h0, valid}, 64'h0);
    check("sb_done_busy", {63'h0, busy}, 64'h0);
    check("empty_hold_addr", {32'h0, m_addr}, 64'h100);
    check("empty_hold_data", {32'h0, m_data}, 64'hA5A5_A5A5);

    // SH then SW, stalled then drained in order
    ready = 1'b0;
    drive(DRAM_WR_H, 32'h202, 32'h0000_1234);
    expect_xfer(32'h200, 32'h1234_1234, 4'b1100);
    tick();
    drive(DRAM_WR_W, 32'h204, 32'hDEAD_BEEF);
    expect_xfer(32'h204, 32'hDEAD_BEEF, 4'b1111);
    tick();
    idle();
    check("sh_addr", {32'h0, m_addr}, 64'h200);
    check("sh_be", {60'h0, m_be}, 64'hC);
    tick();
    check("stall_hold_data", {32'h0, m_data}, 64'h1234_1234);
    ready = 1'b1;
    tick();
    check("sw_addr", {32'h0, m_addr}, 64'h204);
    check("sw_data", {32'h0, m_data}, 64'hDEAD_BEEF);
    tick();
    check("shsw_busy", {63'h0, busy}, 64'h0);

    // Fill to full with ready low; fifth request refused
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(DRAM_WR_W, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i));
      if (i < 4) expect_xfer(32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF);
      tick();
      if (i == 2) check("full_at_3", {63'h0, full}, 64'h0);
      if (i == 3) check("full_at_4", {63'h0, full}, 64'h1);
    end
    idle();
    check("full_after_5", {63'h0, full}, 64'h1);
    check("full_head", {32'h0, m_addr}, 64'h400);
    ready = 1'b1;
    tick();
    check("full_drop", {63'h0, full}, 64'h0);
    check("drain_head1", {32'h0, m_addr}, 64'h404);
    tick();
    tick();
    check("drain_busy3", {63'h0, busy}, 64'h1);
    tick();
    check("drain_busy4", {63'h0, busy}, 64'h0);
    check("drain_valid4", {63'h0, valid}, 64'h0);

    // Full with simultaneous enqueue attempt and dequeue
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(DRAM_WR_W, 32'h600 + 32'(4 * i), 32'h2000 + 32'(i));
      expect_xfer(32'h600 + 32'(4 * i), 32'h2000 + 32'(i), 4'hF);
      tick();
    end
    drive(DRAM_WR_W, 32'h610, 32'h2004);
    ready = 1'b1;
    tick();
    idle();
    check("fulldeq_full", {63'h0, full}, 64'h0);
    check("fulldeq_head", {32'h0, m_addr}, 64'h604);
    tick();
    tick();
    tick();
    check("fulldeq_busy", {63'h0, busy}, 64'h0);

    // Misaligned SW, misaligned SH, invalid sel
    drive(DRAM_WR_W, 32'h301, 32'hFFFF_FFFF);
    tick();
    idle();
    check("mis_sw_pulse", {63'h0, misalign}, 64'h1);
    check("mis_sw_busy", {63'h0, busy}, 64'h0);
    tick();
    check("mis_sw_clear", {63'h0, misalign}, 64'h0);
    drive(DRAM_WR_H, 32'h301, 32'h0000_FFFF);
    tick();
    idle();
    check("mis_sh_pulse", {63'h0, misalign}, 64'h1);
    check("mis_sh_busy", {63'h0, busy}, 64'h0);
    tick();
    check("mis_sh_clear", {63'h0, misalign}, 64'h0);
    drive(3'd7, 32'h300, 32'h1111_1111);
    tick();
    idle();
    check("badsel_pulse", {63'h0, misalign}, 64'h0);
    check("badsel_busy", {63'h0, busy}, 64'h0);

    // Ten back-to-back stores wrap the pointers
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(DRAM_WR_W, 32'h800 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      expect_xfer(32'h800 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF);
      tick();
`ifndef DRAM_WR_BUF_BYPASS_EN
      check("wrap_addr", {32'h0, m_addr}, {32'h0, 32'h800 + 32'(4 * i)});
`endif
    end
    idle();
    tick();
    check("wrap_busy", {63'h0, busy}, 64'h0);
    check("wrap_drained", 64'(exp_q.size()), 64'h0);

    // Reset with three entries pending
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(DRAM_WR_W, 32'hA00 + 32'(4 * i), 32'h3000 + 32'(i));
      tick();
    end
    idle();
    check("pre_rst_valid", {63'h0, valid}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'h0, valid}, 64'h0);
    check("mid_rst_busy", {63'h0, busy}, 64'h0);
    check("mid_rst_full", {63'h0, full}, 64'h0);
    check("mid_rst_addr", {32'h0, m_addr}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", {63'h0, busy}, 64'h0);

`ifdef DRAM_WR_BUF_BYPASS_EN
    ready = 1'b1;
    drive(DRAM_WR_B, 32'h0, 32'h0000_005A);
    expect_xfer(32'h0, 32'h5A5A_5A5A, 4'b0001);
    #1;
    check("byp_valid", {63'h0, valid}, 64'h1);
    check("byp_be", {60'h0, m_be}, 64'h1);
    tick();
    idle();
    check("byp_busy", {63'h0, busy}, 64'h0);
`endif

    tick();
    check("final_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
